storage_regfile: RTL
====================

Name: storage_regfile

Overview:
Parametrised successor to the fixed four-entry storage bank: DEPTH entries of WIDTH bits, one write port and two independent registered read ports. Adds per-entry valid tracking, same-cycle write-to-read bypass, a synchronous clear, and out-of-range address detection. Sits between the datapath's result bus and its operand selectors, replacing hard-wired A/B/C/D registers.

Parameters:
WIDTH, 8, data width of every entry (>=1)
DEPTH, 4, number of entries (>=2, need not be a power of 2)
ADDR_W, $clog2(DEPTH), address width (localparam, derived)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous active-high reset
CLR  in  1  synchronous clear of all entries and valid bits
WR_EN  in  1  write strobe
WR_ADDR  in  ADDR_W  write address
WR_DATA  in  WIDTH  write data
RD_A_EN  in  1  read-port A request
RD_A_ADDR  in  ADDR_W  read-port A address
RD_A_DATA  out  WIDTH  read-port A data, registered
RD_A_HIT  out  1  port A entry was valid at read
RD_A_VLD  out  1  port A response strobe
RD_B_EN, RD_B_ADDR, RD_B_DATA, RD_B_HIT, RD_B_VLD: same as port A, independent
VALID_MASK  out  DEPTH  per-entry valid bits, bit i = entry i
ADDR_ERR  out  1  sticky: any enabled access used an address >= DEPTH

Behaviour:
- Reset (RST=1, async): all entries 0, VALID_MASK 0, RD_x_DATA 0, RD_x_HIT 0, RD_x_VLD 0, ADDR_ERR 0. Released synchronously to CLK by the surrounding design.
- Write: WR_EN=1 and WR_ADDR<DEPTH -> entry[WR_ADDR]<=WR_DATA, VALID_MASK[WR_ADDR]<=1 at the same edge. Write latency 1 cycle.
- Read: RD_x_EN=1 at edge N -> at edge N+1 outputs RD_x_VLD=1, RD_x_DATA=entry, RD_x_HIT=valid bit. Read latency exactly 1 cycle; one result per request, back-to-back every cycle.
- RD_x_EN=0: RD_x_VLD=0 next cycle; RD_x_DATA and RD_x_HIT hold their previous values.
- Bypass: read and write to the same valid address in the same cycle -> RD_x_DATA=WR_DATA, RD_x_HIT=1 (new data, never stale). Applies independently to both ports; both ports may hit the same address.
- Both ports reading the same address: identical results.
- Out-of-range (address >= DEPTH, only possible when DEPTH is not a power of 2): write ignored; read returns DATA=0, HIT=0, VLD=1; ADDR_ERR<=1 and stays set until RST. ADDR_ERR is not set by addresses on a port whose enable is 0.
- CLR=1: at the edge, all entries<=0, VALID_MASK<=0. CLR has priority: a same-cycle write is discarded. Same-cycle reads still complete (VLD=1) with DATA=0, HIT=0. ADDR_ERR unaffected by CLR.
- Reset mid-operation: pending read responses are dropped (VLD forced 0); no partial writes.
- No combinational path from any input to any output.

Decomposition:
- Shared package storage_pkg: ADDR_W derivation function (clog2 with minimum 1), and a reset-value constant for entry data.
- One sub-module natural: storage_rd_port (address range check, bypass mux, output register, VLD/HIT generation), instantiated twice. The entry array, valid bits, clear and write logic stay in the top.

Test Plan:
- Reset then read all addresses, DEPTH=4, WIDTH=8 -> each response VLD=1, HIT=0, DATA=0x00; VALID_MASK=4'b0000.
- Write 0xA5 to addr 2, next cycle read A addr 2 and B addr 1 -> A: DATA=0xA5 HIT=1; B: DATA=0x00 HIT=0; VALID_MASK=4'b0100.
- Same cycle write 0x3C to addr 3 and read A,B addr 3 -> both ports DATA=0x3C HIT=1 next cycle (bypass).
- Fill all 4 entries, then CLR together with write 0xFF to addr 0 and read A addr 0 -> read DATA=0x00 HIT=0; afterwards VALID_MASK=0, entry 0 reads 0x00.
- DEPTH=5 (ADDR_W=3): write 0x77 to addr 6, then read addr 6 -> no entry changes, read DATA=0 HIT=0 VLD=1, ADDR_ERR=1 and remains 1 after a CLR; cleared only by RST.
- Assert RST asynchronously mid-cycle while RD_A_EN=1 -> RD_A_VLD=0 and all outputs 0 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/storage_pkg.sv
// Shared definitions for the storage register file and its read ports.
package storage_pkg;

  // Address width for a given depth: ceil(log2(depth)), never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Value every entry takes on reset or clear, replicated across the data width.
  localparam logic ENTRY_RST_BIT = 1'b0;

endpackage

// File: rtl/storage_rd_port.sv
// One registered read port: range check, write-to-read bypass and the
// response register. The entry array and valid bits are owned by the top.
module storage_rd_port
  import storage_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] entries,
  input  logic [DEPTH-1:0]            valid_mask,
  input  logic [DEPTH-1:0]            wr_sel,     // decoded write, already in range
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            data,
  output logic                        hit,
  output logic                        vld,
  output logic                        addr_err    // this port's enabled read is out of range
);

  logic [DEPTH-1:0] rd_sel;
  logic [WIDTH-1:0] next_data;
  logic             next_hit;

  // Decode the read address and pick stored, bypassed or zero data.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    rd_sel    = '0;
    next_data = {WIDTH{ENTRY_RST_BIT}};
    next_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_sel[i] = (addr == ADDR_W'(i));
    end
    // A clear in the same cycle wins over both storage and bypass.
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_sel[i]) begin
          if (wr_sel[i]) begin
            next_data = wr_data;
            next_hit  = 1'b1;
          end else begin
            next_data = entries[i];
            next_hit  = valid_mask[i];
          end
        end
      end
    end
  end

  // No decoded entry means the address is beyond DEPTH.
  assign addr_err = en && (rd_sel == '0);

  // Response register: strobe every cycle, data/hit only updated on a request.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      data <= {WIDTH{ENTRY_RST_BIT}};
      hit  <= 1'b0;
      vld  <= 1'b0;
    end else begin
      vld <= en;
      if (en) begin
        data <= next_data;
        hit  <= next_hit;
      end
    end
  end

endmodule

// File: rtl/storage_regfile.sv
// DEPTH x WIDTH register file: one write port, two registered read ports,
// per-entry valid bits, synchronous clear and sticky out-of-range flag.
module storage_regfile
  import storage_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic              RD_A_EN,
  input  logic [ADDR_W-1:0] RD_A_ADDR,
  output logic [WIDTH-1:0]  RD_A_DATA,
  output logic              RD_A_HIT,
  output logic              RD_A_VLD,
  input  logic              RD_B_EN,
  input  logic [ADDR_W-1:0] RD_B_ADDR,
  output logic [WIDTH-1:0]  RD_B_DATA,
  output logic              RD_B_HIT,
  output logic              RD_B_VLD,
  output logic [DEPTH-1:0]  VALID_MASK,
  output logic              ADDR_ERR
);

  localparam logic [DEPTH-1:0][WIDTH-1:0] ENTRIES_RST = {DEPTH{{WIDTH{ENTRY_RST_BIT}}}};

  logic [DEPTH-1:0][WIDTH-1:0] entries;
  logic [DEPTH-1:0]            wr_sel;
  logic                        wr_err;
  logic                        a_err;
  logic                        b_err;

  // One-hot write decode; an out-of-range address selects nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i] = WR_EN && (WR_ADDR == ADDR_W'(i));
    end
  end

  assign wr_err = WR_EN && (wr_sel == '0);

  // Entry array and valid bits: reset and clear zero everything, clear beats a write.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: the array is reset on purpose, because a read of a never-written entry must return zero data.
    if (RST) begin
      entries    <= ENTRIES_RST;
      VALID_MASK <= '0;
    end else if (CLR) begin
      entries    <= ENTRIES_RST;
      VALID_MASK <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          entries[i]    <= WR_DATA;
          VALID_MASK[i] <= 1'b1;
        end
      end
    end
  end

  // Sticky range error from any enabled access; only reset clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ADDR_ERR <= 1'b0;
    end else if (wr_err || a_err || b_err) begin
      ADDR_ERR <= 1'b1;
    end
  end

  storage_rd_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rd_a (
    .clk       (CLK),
    .rst       (RST),
    .clr       (CLR),
    .en        (RD_A_EN),
    .addr      (RD_A_ADDR),
    .entries   (entries),
    .valid_mask(VALID_MASK),
    .wr_sel    (wr_sel),
    .wr_data   (WR_DATA),
    .data      (RD_A_DATA),
    .hit       (RD_A_HIT),
    .vld       (RD_A_VLD),
    .addr_err  (a_err)
  );

  storage_rd_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rd_b (
    .clk       (CLK),
    .rst       (RST),
    .clr       (CLR),
    .en        (RD_B_EN),
    .addr      (RD_B_ADDR),
    .entries   (entries),
    .valid_mask(VALID_MASK),
    .wr_sel    (wr_sel),
    .wr_data   (WR_DATA),
    .data      (RD_B_DATA),
    .hit       (RD_B_HIT),
    .vld       (RD_B_VLD),
    .addr_err  (b_err)
  );

endmodule
